// File: rtl/instr_mem_loadable_if.sv
// Bundle of fetch-port and program-load-port signals for instr_mem_loadable.
//   master : fetch/PC side and bootloader side (drives requests, load data)
//   slave  : the instruction memory (drives fetch results and load status)
// Signals:
//   fetch_req/fetch_addr            fetch request and byte address
//   fetch_ready                     fetch accepted this cycle
//   fetch_valid/instruction/fault   registered fetch result, 1 cycle after accept
//   prog_en/prog_start/prog_we      load-mode request, pointer reset, word write
//   prog_data                       word to load
//   prog_count/prog_ovf             words loaded since prog_start, sticky overflow
interface instr_mem_loadable_if #(
  parameter int unsigned INS_ADDRESS = 32,
  parameter int unsigned INS_W       = 32,
  parameter int unsigned DEPTH       = 64
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic                   fetch_req;
  logic [INS_ADDRESS-1:0] fetch_addr;
  logic                   fetch_ready;
  logic                   fetch_valid;
  logic [INS_W-1:0]       instruction;
  logic                   fetch_fault;
  logic                   prog_en;
  logic                   prog_start;
  logic                   prog_we;
  logic [INS_W-1:0]       prog_data;
  logic [CW-1:0]          prog_count;
  logic                   prog_ovf;

  modport master (
    output fetch_req, fetch_addr, prog_en, prog_start, prog_we, prog_data,
    input  fetch_ready, fetch_valid, instruction, fetch_fault, prog_count, prog_ovf
  );

  modport slave (
    input  fetch_req, fetch_addr, prog_en, prog_start, prog_we, prog_data,
    output fetch_ready, fetch_valid, instruction, fetch_fault, prog_count, prog_ovf
  );
endinterface

// File: rtl/instr_mem_loadable.sv
// Loadable instruction memory for the RISC-V core.
//   Fetch port: word-aligned byte address, 1-cycle registered read, fully pipelined,
//   misaligned/out-of-range addresses return NOP with fetch_fault.
//   Load port: in PROG mode, words are streamed in through an auto-incrementing pointer
//   that saturates at DEPTH (further writes set the sticky prog_ovf).
// Ports:
//   i_clk  rising-edge clock
//   i_rst  synchronous active-high reset (memory array is not cleared)
//   bus    instr_mem_loadable_if.slave, see the interface file for signal list
module instr_mem_loadable #(
  parameter int unsigned      INS_ADDRESS = 32,
  parameter int unsigned      INS_W       = 32,
  parameter int unsigned      DEPTH       = 64,
  parameter logic [INS_W-1:0] NOP_INSTR   = 32'h0000_0013
) (
  input logic                  i_clk,
  input logic                  i_rst,
  instr_mem_loadable_if.slave  bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0]          PTR_FULL   = CW'(DEPTH);
  localparam logic [INS_ADDRESS:0]   ADDR_LIMIT = (INS_ADDRESS + 1)'(DEPTH * 4);

  typedef enum logic {StRun, StProg} state_e;

  state_e            r_state;
  state_e            w_state_next;
  logic [INS_W-1:0]  r_mem [DEPTH];
  logic              r_valid;
  logic              r_fault;
  logic [INS_W-1:0]  r_instr;
  logic [CW-1:0]     r_ptr;
  logic              r_ovf;

  logic              w_in_prog;
  logic              w_fetch_ready;
  logic              w_accept;
  logic              w_fault;
  logic [AW-1:0]     w_idx;
  logic              w_ptr_full;
  logic              w_mem_we;

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StRun:   if (bus.prog_en)  w_state_next = StProg;
      StProg:  if (!bus.prog_en) w_state_next = StRun;
      default: w_state_next = StRun;
    endcase
  end

  always_comb begin
    w_in_prog     = (r_state == StProg);
    w_fetch_ready = (r_state == StRun) && !bus.prog_en;
    w_accept      = bus.fetch_req && w_fetch_ready;
    // Zero-extend by one bit so DEPTH*4 can never overflow the address width
    w_fault       = (bus.fetch_addr[1:0] != 2'b00) ||
                    ({1'b0, bus.fetch_addr} >= ADDR_LIMIT);
    w_idx         = bus.fetch_addr[2 +: AW];
    w_ptr_full    = (r_ptr == PTR_FULL);
    // prog_start takes priority over a same-cycle write
    w_mem_we      = !i_rst && w_in_prog && !bus.prog_start && bus.prog_we && !w_ptr_full;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StRun;
      r_valid <= 1'b0;
      r_fault <= 1'b0;
      r_instr <= NOP_INSTR;
      r_ptr   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_valid <= w_accept;
      r_fault <= w_accept && w_fault;
      // instruction holds its last value when nothing was accepted
      if (w_accept) begin
        r_instr <= w_fault ? NOP_INSTR : r_mem[w_idx];
      end
      if (w_in_prog) begin
        if (bus.prog_start) begin
          r_ptr <= '0;
          r_ovf <= 1'b0;
        end else if (bus.prog_we) begin
          if (w_ptr_full) r_ovf <= 1'b1;
          else            r_ptr <= r_ptr + 1'b1;
        end
      end
    end
  end

  // Array has no reset so it survives i_rst and maps onto plain RAM
  always_ff @(posedge i_clk) begin
    if (w_mem_we) begin
      r_mem[r_ptr[AW-1:0]] <= bus.prog_data;
    end
  end

  assign bus.fetch_ready = w_fetch_ready;
  assign bus.fetch_valid = r_valid;
  assign bus.fetch_fault = r_fault;
  assign bus.instruction = r_instr;
  assign bus.prog_count  = r_ptr;
  assign bus.prog_ovf    = r_ovf;
endmodule

// File: tb/tb_instr_mem_loadable.sv
module tb_instr_mem_loadable;
  localparam int unsigned INS_ADDRESS = 32;
  localparam int unsigned INS_W       = 32;
  localparam int unsigned DEPTH       = 64;
  localparam logic [31:0] NOP         = 32'h0000_0013;

  logic clk;
  logic rst;
  int   n_total;
  int   n_pass;

  instr_mem_loadable_if #(
    .INS_ADDRESS(INS_ADDRESS),
    .INS_W      (INS_W),
    .DEPTH      (DEPTH)
  ) u_if ();

  instr_mem_loadable #(
    .INS_ADDRESS(INS_ADDRESS),
    .INS_W      (INS_W),
    .DEPTH      (DEPTH),
    .NOP_INSTR  (NOP)
  ) u_dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1ns after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_total++;
    if (u_if.fetch_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", u_if.fetch_valid);
    else n_pass++;
    n_total++;
    if (u_if.instruction !== NOP) $display("FAIL reset_instr: got %h want %h", u_if.instruction, NOP);
    else n_pass++;
    n_total++;
    if (u_if.prog_count !== 7'd0) $display("FAIL reset_count: got %0d want 0", u_if.prog_count);
    else n_pass++;
    n_total++;
    if (u_if.prog_ovf !== 1'b0) $display("FAIL reset_ovf: got %b want 0", u_if.prog_ovf);
    else n_pass++;
    n_total++;
    if (u_if.fetch_fault !== 1'b0) $display("FAIL reset_fault: got %b want 0", u_if.fetch_fault);
    else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_load_and_fetch();
    logic [31:0] words [3];
    words[0] = 32'h0020_0093;
    words[1] = 32'h0010_0113;
    words[2] = 32'h0030_0193;
    u_if.prog_en = 1'b1;
    tick();
    u_if.prog_start = 1'b1;
    tick();
    u_if.prog_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      u_if.prog_we   = 1'b1;
      u_if.prog_data = words[i];
      tick();
    end
    u_if.prog_we = 1'b0;
    n_total++;
    if (u_if.prog_count !== 7'd3) $display("FAIL load_count: got %0d want 3", u_if.prog_count);
    else n_pass++;
    u_if.prog_en = 1'b0;
    tick();
    n_total++;
    if (u_if.fetch_ready !== 1'b1) $display("FAIL run_ready: got %b want 1", u_if.fetch_ready);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      u_if.fetch_req  = 1'b1;
      u_if.fetch_addr = 32'(i * 4);
      tick();
      n_total++;
      if (u_if.fetch_valid !== 1'b1 || u_if.fetch_fault !== 1'b0 || u_if.instruction !== words[i])
        $display("FAIL b2b_fetch%0d: got v=%b f=%b %h want v=1 f=0 %h", i, u_if.fetch_valid,
                 u_if.fetch_fault, u_if.instruction, words[i]);
      else n_pass++;
    end
    u_if.fetch_req = 1'b0;
    tick();
    n_total++;
    if (u_if.fetch_valid !== 1'b0 || u_if.instruction !== words[2])
      $display("FAIL idle_hold: got v=%b %h want v=0 %h", u_if.fetch_valid, u_if.instruction,
               words[2]);
    else n_pass++;
  endtask

  task automatic test_fault();
    u_if.fetch_req  = 1'b1;
    u_if.fetch_addr = 32'd6;
    tick();
    n_total++;
    if (u_if.fetch_valid !== 1'b1 || u_if.fetch_fault !== 1'b1 || u_if.instruction !== NOP)
      $display("FAIL fault_misaligned: got v=%b f=%b %h want v=1 f=1 %h", u_if.fetch_valid,
               u_if.fetch_fault, u_if.instruction, NOP);
    else n_pass++;
    u_if.fetch_addr = 32'd4;
    tick();
    n_total++;
    if (u_if.fetch_fault !== 1'b0 || u_if.instruction !== 32'h0010_0113)
      $display("FAIL fault_recover: got f=%b %h want f=0 00100113", u_if.fetch_fault,
               u_if.instruction);
    else n_pass++;
    u_if.fetch_addr = 32'd256;
    tick();
    n_total++;
    if (u_if.fetch_valid !== 1'b1 || u_if.fetch_fault !== 1'b1 || u_if.instruction !== NOP)
      $display("FAIL fault_range: got v=%b f=%b %h want v=1 f=1 %h", u_if.fetch_valid,
               u_if.fetch_fault, u_if.instruction, NOP);
    else n_pass++;
    u_if.fetch_addr = 32'h8000_0000;
    tick();
    n_total++;
    if (u_if.fetch_fault !== 1'b1 || u_if.instruction !== NOP)
      $display("FAIL fault_high: got f=%b %h want f=1 %h", u_if.fetch_fault, u_if.instruction,
               NOP);
    else n_pass++;
    u_if.fetch_addr = 32'd252;
    tick();
    n_total++;
    if (u_if.fetch_valid !== 1'b1 || u_if.fetch_fault !== 1'b0)
      $display("FAIL last_word_ok: got v=%b f=%b want v=1 f=0", u_if.fetch_valid,
               u_if.fetch_fault);
    else n_pass++;
    u_if.fetch_req = 1'b0;
    tick();
  endtask

  task automatic test_overflow();
    u_if.prog_en = 1'b1;
    tick();
    u_if.prog_start = 1'b1;
    tick();
    u_if.prog_start = 1'b0;
    for (int i = 0; i <= int'(DEPTH); i++) begin
      u_if.prog_we   = 1'b1;
      u_if.prog_data = 32'hA000_0000 + 32'(i);
      tick();
    end
    u_if.prog_we = 1'b0;
    n_total++;
    if (u_if.prog_count !== 7'd64) $display("FAIL ovf_count: got %0d want 64", u_if.prog_count);
    else n_pass++;
    n_total++;
    if (u_if.prog_ovf !== 1'b1) $display("FAIL ovf_flag: got %b want 1", u_if.prog_ovf);
    else n_pass++;
    u_if.prog_en = 1'b0;
    tick();
    u_if.fetch_req  = 1'b1;
    u_if.fetch_addr = 32'd0;
    tick();
    n_total++;
    if (u_if.instruction !== 32'hA000_0000)
      $display("FAIL ovf_mem0: got %h want a0000000", u_if.instruction);
    else n_pass++;
    u_if.fetch_addr = 32'd252;
    tick();
    n_total++;
    if (u_if.instruction !== 32'hA000_003F)
      $display("FAIL ovf_mem63: got %h want a000003f", u_if.instruction);
    else n_pass++;
    u_if.fetch_req = 1'b0;
    // ovf stays sticky across RUN
    n_total++;
    if (u_if.prog_ovf !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", u_if.prog_ovf);
    else n_pass++;
    u_if.prog_en = 1'b1;
    tick();
    u_if.prog_start = 1'b1;
    u_if.prog_we    = 1'b1;
    u_if.prog_data  = 32'hDEAD_BEEF;
    tick();
    u_if.prog_start = 1'b0;
    u_if.prog_we    = 1'b0;
    n_total++;
    if (u_if.prog_ovf !== 1'b0 || u_if.prog_count !== 7'd0)
      $display("FAIL start_clears: got ovf=%b cnt=%0d want ovf=0 cnt=0", u_if.prog_ovf,
               u_if.prog_count);
    else n_pass++;
    u_if.prog_en = 1'b0;
    tick();
    u_if.fetch_req  = 1'b1;
    u_if.fetch_addr = 32'd0;
    tick();
    u_if.fetch_req = 1'b0;
    n_total++;
    if (u_if.instruction !== 32'hA000_0000)
      $display("FAIL start_drops_we: got %h want a0000000", u_if.instruction);
    else n_pass++;
  endtask

  task automatic test_hold_during_prog();
    u_if.prog_en    = 1'b1;
    u_if.fetch_req  = 1'b1;
    u_if.fetch_addr = 32'd8;
    #1;
    n_total++;
    if (u_if.fetch_ready !== 1'b0) $display("FAIL hold_ready_comb: got %b want 0", u_if.fetch_ready);
    else n_pass++;
    tick();
    tick();
    n_total++;
    if (u_if.fetch_valid !== 1'b0 || u_if.fetch_ready !== 1'b0)
      $display("FAIL hold_no_valid: got v=%b r=%b want v=0 r=0", u_if.fetch_valid,
               u_if.fetch_ready);
    else n_pass++;
    u_if.prog_en = 1'b0;
    tick();
    n_total++;
    if (u_if.fetch_ready !== 1'b1 || u_if.fetch_valid !== 1'b0)
      $display("FAIL hold_resume: got r=%b v=%b want r=1 v=0", u_if.fetch_ready,
               u_if.fetch_valid);
    else n_pass++;
    tick();
    n_total++;
    if (u_if.fetch_valid !== 1'b1 || u_if.instruction !== 32'hA000_0002)
      $display("FAIL hold_served: got v=%b %h want v=1 a0000002", u_if.fetch_valid,
               u_if.instruction);
    else n_pass++;
    // Result pending when prog_en rises is still delivered
    u_if.fetch_addr = 32'd12;
    tick();
    u_if.fetch_req = 1'b0;
    u_if.prog_en   = 1'b1;
    tick();
    n_total++;
    if (u_if.fetch_valid !== 1'b0)
      $display("FAIL pending_then_prog: got v=%b want 0", u_if.fetch_valid);
    else n_pass++;
    u_if.prog_en = 1'b0;
    tick();
  endtask

  task automatic test_pending_delivery();
    u_if.fetch_req  = 1'b1;
    u_if.fetch_addr = 32'd16;
    tick();
    u_if.fetch_req = 1'b0;
    u_if.prog_en   = 1'b1;
    #1;
    n_total++;
    if (u_if.fetch_valid !== 1'b1 || u_if.instruction !== 32'hA000_0004)
      $display("FAIL pending_delivered: got v=%b %h want v=1 a0000004", u_if.fetch_valid,
               u_if.instruction);
    else n_pass++;
    tick();
    u_if.prog_en = 1'b0;
    tick();
  endtask

  task automatic test_resume_and_reset();
    u_if.prog_en = 1'b1;
    tick();
    u_if.prog_start = 1'b1;
    tick();
    u_if.prog_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      u_if.prog_we   = 1'b1;
      u_if.prog_data = 32'hD000_0000 + 32'(i);
      tick();
    end
    u_if.prog_we = 1'b0;
    u_if.prog_en = 1'b0;
    tick();
    // Writes in RUN are ignored
    u_if.prog_we    = 1'b1;
    u_if.prog_start = 1'b1;
    u_if.prog_data  = 32'hBAD0_0000;
    tick();
    u_if.prog_we    = 1'b0;
    u_if.prog_start = 1'b0;
    n_total++;
    if (u_if.prog_count !== 7'd3) $display("FAIL run_ignores_we: got %0d want 3", u_if.prog_count);
    else n_pass++;
    u_if.prog_en = 1'b1;
    tick();
    for (int i = 3; i < 5; i++) begin
      u_if.prog_we   = 1'b1;
      u_if.prog_data = 32'hD000_0000 + 32'(i);
      tick();
    end
    u_if.prog_we = 1'b0;
    n_total++;
    if (u_if.prog_count !== 7'd5) $display("FAIL resume_count: got %0d want 5", u_if.prog_count);
    else n_pass++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    u_if.prog_en = 1'b0;
    #1;
    n_total++;
    if (u_if.prog_count !== 7'd0 || u_if.prog_ovf !== 1'b0 || u_if.fetch_ready !== 1'b1)
      $display("FAIL midprog_reset: got cnt=%0d ovf=%b r=%b want cnt=0 ovf=0 r=1",
               u_if.prog_count, u_if.prog_ovf, u_if.fetch_ready);
    else n_pass++;
    for (int i = 0; i < 6; i++) begin
      logic [31:0] exp;
      exp = (i < 5) ? 32'hD000_0000 + 32'(i) : 32'hA000_0005;
      u_if.fetch_req  = 1'b1;
      u_if.fetch_addr = 32'(i * 4);
      tick();
      n_total++;
      if (u_if.fetch_valid !== 1'b1 || u_if.instruction !== exp)
        $display("FAIL after_reset_mem%0d: got v=%b %h want v=1 %h", i, u_if.fetch_valid,
                 u_if.instruction, exp);
      else n_pass++;
    end
    u_if.fetch_req = 1'b0;
    tick();
  endtask

  initial begin
    n_total         = 0;
    n_pass          = 0;
    rst             = 1'b1;
    u_if.fetch_req  = 1'b0;
    u_if.fetch_addr = '0;
    u_if.prog_en    = 1'b0;
    u_if.prog_start = 1'b0;
    u_if.prog_we    = 1'b0;
    u_if.prog_data  = '0;
    #1;
    test_reset();
    test_load_and_fetch();
    test_fault();
    test_overflow();
    test_hold_during_prog();
    test_pending_delivery();
    test_resume_and_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
